line_stepper: RTL and testbench
===============================

Name: line_stepper

Overview:
- Responder end of the render controller's line-draw handshake.
- Accepts a line segment on `set_new`. Emits one pixel coordinate per `draw_enable` pulse using integer Bresenham stepping.
- Asserts `done` when the emitted pixel equals the segment endpoint.
- Sits between the render controller and the frame-buffer write path. `x_out`/`y_out` feed the pixel write address.

Parameters:
- COORD_W, 10, bit width of each coordinate. Unsigned; 10 covers 640x480.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- draw_enable  in  1  single-cycle step strobe from the render controller
- set_new  in  1  load new segment. Qualified by draw_enable; ignored without it.
- x0  in  COORD_W  start x (sampled on load)
- y0  in  COORD_W  start y
- x1  in  COORD_W  end x
- y1  in  COORD_W  end y
- x_out  out  COORD_W  current pixel x
- y_out  out  COORD_W  current pixel y
- done  out  1  current pixel is the segment endpoint
- busy  out  1  segment loaded and not yet finished

Behaviour:
- Reset (async, `rst`=1): state=IDLE; x_out=y_out=0; done=0; busy=0; all internal registers 0.
- Internal registers:
  - cur_x, cur_y, end_x, end_y
  - dx = |x1-x0|, unsigned COORD_W
  - dy = -|y1-y0|, signed COORD_W+2
  - sx, sy = +1/-1 direction flags
  - err, signed COORD_W+2
  - e2 = 2*err, signed COORD_W+3
- FSM states: IDLE, RUN, FIN.
- Load (draw_enable=1 and set_new=1), accepted in any state:
  - cur<=(x0,y0); end<=(x1,y1).
  - dx, dy, sx, sy latched; err<=dx+dy.
  - Next state = FIN if (x0,y0)==(x1,y1), else RUN.
- Step (draw_enable=1, set_new=0, state RUN):
  - Both updates below use the old err; they may both apply in the same cycle.
  - If e2>=dy: err+=dy, cur_x+=sx.
  - If e2<=dx: err+=dx, cur_y+=sy.
  - Go to FIN when the next (cur_x,cur_y)==end; else stay in RUN.
- Step in IDLE or FIN: no change to coordinates or error, no state change.
- draw_enable=0: hold all state. set_new alone is ignored.
- Latency: x_out/y_out/done update on the same rising edge that samples draw_enable. They are valid one cycle after the strobe, well before the controller samples done two cycles after its send cycle.
- Outputs:
  - done=1 exactly when state==FIN. Held until the next load or reset.
  - busy=1 exactly when state==RUN.
- Coordinates never leave the bounding box of (x0,y0)-(x1,y1). No wrap can occur for in-range inputs.
- Input change: x0..y1 changing outside a load cycle has no effect.
- Reload mid-line: a load in RUN abandons the current segment immediately.
- Reset mid-line: immediate return to reset values.

Decomposition:
- Shared package render_pkg holds:
  - COORD_W default constant
  - the line_stepper state enum (IDLE, RUN, FIN) as a 2-bit typedef
  - the signed error-width constant COORD_W+2
- Natural sub-module: line_setup, combinational.
  - Inputs: x0, y0, x1, y1.
  - Outputs: dx, dy, sx, sy, initial err.
  - Instantiated once. Keeps the sequential stepper core small.

Test Plan:
- Horizontal line: load (0,0)->(3,0).
  - Outputs (0,0) done=0 busy=1.
  - Three steps give (1,0),(2,0),(3,0); done rises on the third; busy falls.
- Steep line: load (0,0)->(1,3), err0=-2.
  - Steps give (0,1),(1,2),(1,3); done=1 only on the final pixel.
- Negative diagonal: load (5,5)->(2,2).
  - Steps give (4,4),(3,3),(2,2) with sx=sy=-1.
  - Two further steps in FIN leave (2,2) and done=1.
- Zero-length line: load (7,9)->(7,9).
  - Next cycle shows (7,9), done=1, busy=0.
  - A step leaves all outputs unchanged.
- Mid-line events: load (0,0)->(10,0), step twice, then pulse rst asynchronously between edges.
  - Outputs go to 0/IDLE immediately; a step afterward changes nothing.
  - Repeat with a reload of (3,3)->(3,5) at step 2; output becomes (3,3).
- Strobe qualification: set_new=1 with draw_enable=0, with x0..y1 changing every cycle.
  - No output change.
  - Holding draw_enable low between steps freezes cur and err.

Source files
------------

// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// render_pkg : shared types and constants for the render line-draw path.
// Revision 1.0
// ============================================================================
package render_pkg;

  localparam int C_COORD_W = 10;
  // Room for -|dy| plus a sign bit and the worst-case excursion of err.
  localparam int C_ERR_W   = C_COORD_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } stepper_state_e;

endpackage
`default_nettype wire

// File: rtl/line_setup.sv
`default_nettype none
// ============================================================================
// line_setup : combinational Bresenham setup (deltas, directions, initial err).
// Revision 1.0
// ============================================================================
module line_setup
  import render_pkg::*;
#(
  parameter int COORD_W = C_COORD_W,
  parameter int ERR_W   = C_ERR_W
) (
  input  logic [COORD_W-1:0]      x0_i,
  input  logic [COORD_W-1:0]      y0_i,
  input  logic [COORD_W-1:0]      x1_i,
  input  logic [COORD_W-1:0]      y1_i,
  output logic [COORD_W-1:0]      dx_o,
  output logic signed [ERR_W-1:0] dy_o,
  output logic                    sx_neg_o,
  output logic                    sy_neg_o,
  output logic signed [ERR_W-1:0] err_o
);

  logic [COORD_W-1:0]      w_ady;
  logic signed [ERR_W-1:0] w_dx_ext;
  logic signed [ERR_W-1:0] w_ady_ext;

  assign sx_neg_o = (x1_i < x0_i);
  assign sy_neg_o = (y1_i < y0_i);

  assign dx_o  = sx_neg_o ? (x0_i - x1_i) : (x1_i - x0_i);
  assign w_ady = sy_neg_o ? (y0_i - y1_i) : (y1_i - y0_i);

  assign w_dx_ext  = {{(ERR_W-COORD_W){1'b0}}, dx_o};
  assign w_ady_ext = {{(ERR_W-COORD_W){1'b0}}, w_ady};

  // dy is kept negative so every step is a plain signed add of dx or dy.
  assign dy_o  = -w_ady_ext;
  assign err_o = w_dx_ext + dy_o;

endmodule
`default_nettype wire

// File: rtl/line_stepper.sv
`default_nettype none
// ============================================================================
// line_stepper : emits one Bresenham pixel per draw_enable strobe.
// Revision 1.0
// ============================================================================
module line_stepper
  import render_pkg::*;
#(
  parameter int COORD_W = C_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               draw_enable,
  input  logic               set_new,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               done,
  output logic               busy
);

  localparam int ERR_W = COORD_W + (C_ERR_W - C_COORD_W);

  stepper_state_e state_q, state_d;

  logic [COORD_W-1:0]      cur_x_q, cur_x_d;
  logic [COORD_W-1:0]      cur_y_q, cur_y_d;
  logic [COORD_W-1:0]      end_x_q, end_x_d;
  logic [COORD_W-1:0]      end_y_q, end_y_d;
  logic [COORD_W-1:0]      dx_q, dx_d;
  logic signed [ERR_W-1:0] dy_q, dy_d;
  logic                    sx_neg_q, sx_neg_d;
  logic                    sy_neg_q, sy_neg_d;
  logic signed [ERR_W-1:0] err_q, err_d;

  logic [COORD_W-1:0]      w_set_dx;
  logic signed [ERR_W-1:0] w_set_dy;
  logic signed [ERR_W-1:0] w_set_err;
  logic                    w_set_sx_neg;
  logic                    w_set_sy_neg;

  logic                    w_load;
  logic                    w_step;
  logic                    w_zero_len;
  logic signed [ERR_W:0]   w_e2;
  logic signed [ERR_W:0]   w_dy_wide;
  logic signed [ERR_W:0]   w_dx_wide;
  logic signed [ERR_W-1:0] w_dx_err;
  logic                    w_step_x;
  logic                    w_step_y;
  logic [COORD_W-1:0]      w_nx;
  logic [COORD_W-1:0]      w_ny;
  logic signed [ERR_W-1:0] w_err_next;

  line_setup #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_setup (
    .x0_i     (x0),
    .y0_i     (y0),
    .x1_i     (x1),
    .y1_i     (y1),
    .dx_o     (w_set_dx),
    .dy_o     (w_set_dy),
    .sx_neg_o (w_set_sx_neg),
    .sy_neg_o (w_set_sy_neg),
    .err_o    (w_set_err)
  );

  assign w_load     = draw_enable & set_new;
  assign w_step     = draw_enable & ~set_new & (state_q == ST_RUN);
  assign w_zero_len = (x0 == x1) && (y0 == y1);

  // Both axis decisions look at the same pre-step error.
  assign w_e2      = {err_q, 1'b0};
  assign w_dy_wide = {dy_q[ERR_W-1], dy_q};
  assign w_dx_wide = {{(ERR_W+1-COORD_W){1'b0}}, dx_q};
  assign w_dx_err  = {{(ERR_W-COORD_W){1'b0}}, dx_q};
  assign w_step_x  = (w_e2 >= w_dy_wide);
  assign w_step_y  = (w_e2 <= w_dx_wide);

  assign w_nx = !w_step_x ? cur_x_q :
                (sx_neg_q ? cur_x_q - COORD_W'(1) : cur_x_q + COORD_W'(1));
  assign w_ny = !w_step_y ? cur_y_q :
                (sy_neg_q ? cur_y_q - COORD_W'(1) : cur_y_q + COORD_W'(1));

  assign w_err_next = err_q + (w_step_x ? dy_q : '0) + (w_step_y ? w_dx_err : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_load) begin
      state_d = w_zero_len ? ST_FIN : ST_RUN;
    end else if (w_step && (w_nx == end_x_q) && (w_ny == end_y_q)) begin
      state_d = ST_FIN;
    end
  end

  always_comb begin
    done  = (state_q == ST_FIN);
    busy  = (state_q == ST_RUN);
    x_out = cur_x_q;
    y_out = cur_y_q;
  end

  always_comb begin
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    if (w_load) begin
      cur_x_d  = x0;
      cur_y_d  = y0;
      end_x_d  = x1;
      end_y_d  = y1;
      dx_d     = w_set_dx;
      dy_d     = w_set_dy;
      sx_neg_d = w_set_sx_neg;
      sy_neg_d = w_set_sy_neg;
      err_d    = w_set_err;
    end else if (w_step) begin
      cur_x_d = w_nx;
      cur_y_d = w_ny;
      err_d   = w_err_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
    end else begin
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      end_x_q  <= end_x_d;
      end_y_q  <= end_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_stepper.sv
`default_nettype none
// ============================================================================
// tb_line_stepper : scoreboard bench for line_stepper.
// Revision 1.0
// ============================================================================
module tb_line_stepper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       draw_enable = 1'b0;
  logic       set_new = 1'b0;
  logic [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [9:0] x_out, y_out;
  logic       done, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int x;
    int y;
    bit done;
    bit busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // reference model: 0 idle, 1 run, 2 fin
  int m_x, m_y, m_ex, m_ey, m_dx, m_dy, m_sx, m_sy, m_err, m_st;

  line_stepper #(.COORD_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .draw_enable (draw_enable),
    .set_new     (set_new),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .x_out       (x_out),
    .y_out       (y_out),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_ex = 0; m_ey = 0; m_dx = 0; m_dy = 0;
    m_sx = 1; m_sy = 1; m_err = 0; m_st = 0;
    sb.delete();
  endtask

  task automatic drive(input bit de, input bit sn, input int ax0, input int ay0,
                       input int ax1, input int ay1);
    int e2;
    @(negedge clk);
    draw_enable = de;
    set_new     = sn;
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    if (de && sn) begin
      m_x = ax0; m_y = ay0; m_ex = ax1; m_ey = ay1;
      m_dx = iabs(ax1 - ax0);
      m_dy = -iabs(ay1 - ay0);
      m_sx = (ax1 < ax0) ? -1 : 1;
      m_sy = (ay1 < ay0) ? -1 : 1;
      m_err = m_dx + m_dy;
      m_st = (ax0 == ax1 && ay0 == ay1) ? 2 : 1;
    end else if (de && m_st == 1) begin
      e2 = 2 * m_err;
      if (e2 >= m_dy) begin m_err += m_dy; m_x += m_sx; end
      if (e2 <= m_dx) begin m_err += m_dx; m_y += m_sy; end
      if (m_x == m_ex && m_y == m_ey) m_st = 2;
    end
    sb.push_back('{m_x, m_y, m_st == 2, m_st == 1});
    @(posedge clk);
    #1;
    draw_enable = 1'b0;
    set_new     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if (x_out !== 10'd0 || y_out !== 10'd0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: got x=%0d y=%0d done=%b busy=%b, want 0 0 0 0",
               x_out, y_out, done, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_horizontal();
    int lx[4] = '{0, 1, 2, 3};
    bit ld[4] = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 1, 0, 0, 3, 0);
      else        drive(1, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy ||
          x_out !== 10'(lx[i]) || y_out !== 10'd0 || done !== ld[i] || busy !== !ld[i]) begin
        bad++;
        $display("FAIL horizontal[%0d]: got (%0d,%0d) done=%b busy=%b, want (%0d,0) done=%b busy=%b",
                 i, x_out, y_out, done, busy, lx[i], ld[i], !ld[i]);
      end
    end
  endtask

  task automatic test_steep();
    int lx[4] = '{0, 0, 1, 1};
    int ly[4] = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 1, 0, 0, 1, 3);
      else        drive(1, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy ||
          x_out !== 10'(lx[i]) || y_out !== 10'(ly[i]) || done !== (i == 3)) begin
        bad++;
        $display("FAIL steep[%0d]: got (%0d,%0d) done=%b busy=%b, want (%0d,%0d) done=%b",
                 i, x_out, y_out, done, busy, lx[i], ly[i], (i == 3));
      end
    end
  endtask

  task automatic test_neg_diag_and_zero();
    // (5,5)->(2,2) plus two steps in FIN, then zero-length (7,9) plus one step
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      drive(1, 1, 5, 5, 2, 2);
      else if (i == 6) drive(1, 1, 7, 9, 7, 9);
      else             drive(1, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy) begin
        bad++;
        $display("FAIL diag_zero[%0d]: got (%0d,%0d) done=%b busy=%b, want (%0d,%0d) done=%b busy=%b",
                 i, x_out, y_out, done, busy, e.x, e.y, e.done, e.busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 1, 0, 0, 10, 0);
      else        drive(1, 0, 0, 0, 0, 0);
      void'(sb.pop_front());
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (x_out !== 10'd0 || y_out !== 10'd0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got x=%0d y=%0d done=%b busy=%b, want 0 0 0 0",
               x_out, y_out, done, busy);
    end
    #1 rst = 1'b0;
    model_reset();
    drive(1, 0, 4, 4, 8, 8);
    e = sb.pop_front();
    total++;
    if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy) begin
      bad++;
      $display("FAIL post_reset_step: got (%0d,%0d) done=%b busy=%b, want (%0d,%0d) done=%b busy=%b",
               x_out, y_out, done, busy, e.x, e.y, e.done, e.busy);
    end
  endtask

  task automatic test_reload();
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(1, 1, 0, 0, 10, 0);
      else if (i == 3) drive(1, 1, 3, 3, 3, 5);
      else             drive(1, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy ||
          (i == 3 && (x_out !== 10'd3 || y_out !== 10'd3))) begin
        bad++;
        $display("FAIL reload[%0d]: got (%0d,%0d) done=%b busy=%b, want (%0d,%0d) done=%b busy=%b",
                 i, x_out, y_out, done, busy, e.x, e.y, e.done, e.busy);
      end
    end
  endtask

  task automatic test_strobe();
    // set_new without draw_enable and idle gaps between steps must freeze state
    for (int i = 0; i < 12; i++) begin
      if (i == 0)
        drive(1, 1, 0, 0, 6, 2);
      else if (i % 3 == 0)
        drive(1, 0, $urandom_range(0, 600), $urandom_range(0, 400),
              $urandom_range(0, 600), $urandom_range(0, 400));
      else
        drive(0, 1, $urandom_range(0, 600), $urandom_range(0, 400),
              $urandom_range(0, 600), $urandom_range(0, 400));
      e = sb.pop_front();
      total++;
      if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy) begin
        bad++;
        $display("FAIL strobe[%0d]: got (%0d,%0d) done=%b busy=%b, want (%0d,%0d) done=%b busy=%b",
                 i, x_out, y_out, done, busy, e.x, e.y, e.done, e.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ax0, ay0, ax1, ay1, n;
    for (int s = 0; s < 6; s++) begin
      ax0 = $urandom_range(0, 30); ay0 = $urandom_range(0, 30);
      ax1 = $urandom_range(0, 30); ay1 = $urandom_range(0, 30);
      drive(1, 1, ax0, ay0, ax1, ay1);
      n = 0;
      while (1) begin
        e = sb.pop_front();
        total++;
        if (x_out !== 10'(e.x) || y_out !== 10'(e.y) || done !== e.done || busy !== e.busy) begin
          bad++;
          $display("FAIL b2b[%0d.%0d]: got (%0d,%0d) done=%b busy=%b, want (%0d,%0d) done=%b busy=%b",
                   s, n, x_out, y_out, done, busy, e.x, e.y, e.done, e.busy);
        end
        if (e.done || n >= 64) break;
        drive(1, 0, 0, 0, 0, 0);
        n++;
      end
      total++;
      if (done !== 1'b1 || x_out !== 10'(ax1) || y_out !== 10'(ay1)) begin
        bad++;
        $display("FAIL b2b_end[%0d]: got (%0d,%0d) done=%b, want (%0d,%0d) done=1",
                 s, x_out, y_out, done, ax1, ay1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_neg_diag_and_zero();
    test_mid_reset();
    test_reload();
    test_strobe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
